lsu_ctrl: RTL and testbench

Load/store control unit between the execute stage and the byte-addressed `data_mem`. It accepts one memory request at a time over a valid/ready handshake and forms the effective address. It checks alignment, range and funct3 legality, then drives `data_mem` for exactly one cycle and returns a registered response (load data or store acknowledge, or an error) to writeback over a second valid/ready handshake.

---
 rtl/lsu_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store control unit between execute and data_mem.
//
// Takes one memory request at a time and forms the effective address
// (base + sign-extended offset). It then checks the request for an illegal
// funct3, a misaligned address or an out-of-range address. A legal request
// drives data_mem for exactly one cycle (ACCESS). Every accepted request
// produces one registered response to writeback.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. The producer holds valid (and its payload) until that edge,
// and ready never depends on valid. Here req_ready is (state == IDLE).
// resp_* outputs are held stable while resp_valid=1 and resp_ready=0.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : request handshake from execute
//   req_store         : 1 = store, 0 = load
//   req_funct3        : RISC-V funct3 of the access
//   req_base/offset   : rs1 value and signed 12-bit immediate
//   req_wdata, req_rd : store data, load destination register
//   dm_rd_en/wr_en    : data_mem enables, high only during ACCESS
//   dm_addr/mode/wdata: data_mem address, access mode and store data
//   dm_rdata          : asynchronous (already extended) read data
//   resp_valid/ready  : response handshake to writeback
//   resp_data/rd/we   : load result, destination, register write enable
//   resp_err/cause    : fault flag and cause (01 misaligned, 10 range, 11 funct3)
//   dbg_state         : current FSM state (IDLE 0, ACCESS 1, RESP 2)
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [11:0] req_offset,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        dm_rd_en,
    output logic        dm_wr_en,
    output logic [31:0] dm_addr,
    output logic [2:0]  dm_mode,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_we,
    output logic        resp_err,
    output logic [1:0]  resp_cause,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE   = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

    state_t state_q, state_d;

    // Request registers
    logic        store_q;
    logic [4:0]  rd_q;
    logic [31:0] dm_addr_q;
    logic [2:0]  dm_mode_q;
    logic [31:0] dm_wdata_q;

    // Response registers
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic [4:0]  resp_rd_q;
    logic        resp_we_q;
    logic        resp_err_q;
    logic [1:0]  resp_cause_q;

    // Request decode (combinational on the live req_* inputs)
    logic [31:0] ea;
    logic        legal_dec;
    logic [2:0]  mode_dec;
    logic [2:0]  size_dec;
    logic        misaligned;
    logic [32:0] last_byte;
    logic        out_of_range;
    logic [1:0]  cause_dec;
    logic        accept;

    assign ea = req_base + {{20{req_offset[11]}}, req_offset};

    always_comb begin
        legal_dec = 1'b0;
        mode_dec  = 3'b000;
        size_dec  = 3'd1;
        case (req_funct3)
            3'b000: begin legal_dec = 1'b1;       mode_dec = 3'b000; size_dec = 3'd1; end
            3'b001: begin legal_dec = 1'b1;       mode_dec = 3'b001; size_dec = 3'd2; end
            3'b010: begin legal_dec = 1'b1;       mode_dec = 3'b010; size_dec = 3'd4; end
            3'b100: begin legal_dec = !req_store; mode_dec = 3'b011; size_dec = 3'd1; end
            3'b101: begin legal_dec = !req_store; mode_dec = 3'b100; size_dec = 3'd2; end
            default: ;
        endcase
    end

    assign misaligned = ((size_dec == 3'd2) && ea[0]) ||
                        ((size_dec == 3'd4) && (ea[1:0] != 2'b00));

    // 33-bit so an address near 2^32 cannot wrap back into range.
    assign last_byte    = {1'b0, ea} + {30'b0, size_dec} - 33'd1;
    assign out_of_range = last_byte > 33'(MEM_BYTES - 1);

    // Priority: illegal funct3 > misaligned > out of range.
    assign cause_dec = !legal_dec  ? CAUSE_ILLEGAL :
                       misaligned   ? CAUSE_MISALGN :
                       out_of_range ? CAUSE_RANGE   : CAUSE_NONE;

    assign accept = req_valid && (state_q == IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and control outputs
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        dm_rd_en  = 1'b0;
        dm_wr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = (cause_dec == CAUSE_NONE) ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                // Gated by rst so a reset in ACCESS never commits a store.
                dm_rd_en = !store_q && !rst;
                dm_wr_en = store_q && !rst;
                state_d  = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q      <= 1'b0;
            rd_q         <= 5'd0;
            dm_addr_q    <= 32'd0;
            dm_mode_q    <= 3'd0;
            dm_wdata_q   <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_rd_q    <= 5'd0;
            resp_we_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_cause_q <= CAUSE_NONE;
        end else begin
            if (accept) begin
                store_q <= req_store;
                rd_q    <= req_rd;
                if (cause_dec == CAUSE_NONE) begin
                    // data_mem outputs only move for a request that will access.
                    dm_addr_q  <= ea;
                    dm_mode_q  <= mode_dec;
                    dm_wdata_q <= req_wdata;
                end else begin
                    // Faulting request skips ACCESS and answers next cycle.
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= 32'd0;
                    resp_rd_q    <= req_rd;
                    resp_we_q    <= 1'b0;
                    resp_err_q   <= 1'b1;
                    resp_cause_q <= cause_dec;
                end
            end
            if (state_q == ACCESS) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= store_q ? 32'd0 : dm_rdata;
                resp_rd_q    <= rd_q;
                resp_we_q    <= !store_q && (rd_q != 5'd0);
                resp_err_q   <= 1'b0;
                resp_cause_q <= CAUSE_NONE;
            end
            if ((state_q == RESP) && resp_ready) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign dm_addr    = dm_addr_q;
    assign dm_mode    = dm_mode_q;
    assign dm_wdata   = dm_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_we    = resp_we_q;
    assign resp_err   = resp_err_q;
    assign resp_cause = resp_cause_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl with a behavioural data_mem.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    localparam int MEM_BYTES = 100;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [11:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        dm_rd_en;
    logic        dm_wr_en;
    logic [31:0] dm_addr;
    logic [2:0]  dm_mode;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_we;
    logic        resp_err;
    logic [1:0]  resp_cause;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_base   (req_base),
        .req_offset (req_offset),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .dm_rd_en   (dm_rd_en),
        .dm_wr_en   (dm_wr_en),
        .dm_addr    (dm_addr),
        .dm_mode    (dm_mode),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_we    (resp_we),
        .resp_err   (resp_err),
        .resp_cause (resp_cause),
        .dbg_state  (dbg_state)
    );

    // ---------------- behavioural data_mem ----------------
    logic [7:0] dm_mem [MEM_BYTES];
    logic [7:0] rb [4];
    logic       mem_load;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rb[k] = (({1'b0, dm_addr} + 33'(k)) < 33'(MEM_BYTES)) ? dm_mem[int'(dm_addr) + k] : 8'h00;
        end
        dm_rdata = 32'd0;
        case (dm_mode)
            3'b000: dm_rdata = {{24{rb[0][7]}}, rb[0]};
            3'b001: dm_rdata = {{16{rb[1][7]}}, rb[1], rb[0]};
            3'b010: dm_rdata = {rb[3], rb[2], rb[1], rb[0]};
            3'b011: dm_rdata = {24'h0, rb[0]};
            3'b100: dm_rdata = {16'h0, rb[1], rb[0]};
            default: dm_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < MEM_BYTES; i++) dm_mem[i] <= 8'(i * 7 + 3);
        end else if (dm_wr_en) begin
            case (dm_mode)
                3'b000: dm_mem[int'(dm_addr)] <= dm_wdata[7:0];
                3'b001: begin
                    dm_mem[int'(dm_addr)]     <= dm_wdata[7:0];
                    dm_mem[int'(dm_addr) + 1] <= dm_wdata[15:8];
                end
                3'b010: begin
                    dm_mem[int'(dm_addr)]     <= dm_wdata[7:0];
                    dm_mem[int'(dm_addr) + 1] <= dm_wdata[15:8];
                    dm_mem[int'(dm_addr) + 2] <= dm_wdata[23:16];
                    dm_mem[int'(dm_addr) + 3] <= dm_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    // ---------------- enable monitor / cycle counter ----------------
    int          en_rd_total = 0;
    int          en_wr_total = 0;
    logic [31:0] en_addr;
    logic [2:0]  en_mode;
    logic [31:0] en_wdata;
    int          cyc = 0;

    always @(negedge clk) begin
        if (dm_rd_en || dm_wr_en) begin
            if (dm_rd_en) en_rd_total++;
            if (dm_wr_en) en_wr_total++;
            en_addr  = dm_addr;
            en_mode  = dm_mode;
            en_wdata = dm_wdata;
        end
    end

    always @(posedge clk) cyc++;

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [40:0] exp_q [$];   // {err, cause[1:0], we, rd[4:0], data[31:0]}

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] m_ea;

    function automatic logic [40:0] model_req(input logic st, input logic [2:0] f3,
                                              input logic [31:0] base, input logic [11:0] off,
                                              input logic [31:0] wd, input logic [4:0] rd);
        int          offs;
        int          size;
        longint      ea;
        longint      v;
        logic        legal;
        logic [1:0]  cause;
        logic [31:0] data;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        offs  = off[11] ? int'(off) - 4096 : int'(off);
        ea    = (longint'(base) + longint'(offs)) & 64'hFFFF_FFFF;
        m_ea  = 32'(ea);
        if (!legal)                        cause = 2'd3;
        else if (ea % size != 0)           cause = 2'd1;
        else if (ea + size - 1 > MEM_BYTES - 1) cause = 2'd2;
        else                               cause = 2'd0;
        data = 32'd0;
        if (cause == 2'd0) begin
            if (st) begin
                for (int k = 0; k < size; k++) ref_mem[int'(ea) + k] = wd[8*k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < size; k++) v += longint'(ref_mem[int'(ea) + k]) << (8 * k);
                if (f3 == 3'd0 && v >= 128)   v -= 256;
                if (f3 == 3'd1 && v >= 32768) v -= 65536;
                data = 32'(v);
            end
        end
        return {cause != 2'd0, cause, (!st && cause == 2'd0 && rd != 5'd0), rd, data};
    endfunction

    // ---------------- driver tasks ----------------
    logic [40:0] got_pack;
    int          got_lat;
    int          acc_cyc;
    int          rd0;
    int          wr0;

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [11:0] off, input logic [31:0] wd, input logic [4:0] rd);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        if (!req_ready) check("req_ready_wait", 64'(req_ready), 64'd1);
        rd0        = en_rd_total;
        wr0        = en_wr_total;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_base   = base;
        req_offset = off;
        req_wdata  = wd;
        req_rd     = rd;
        @(posedge clk); #1;
        acc_cyc    = cyc;
        // Scramble the request bus; the DUT must have sampled it already.
        req_valid  = 1'b0;
        req_store  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_base   = $urandom;
        req_offset = 12'($urandom);
        req_wdata  = $urandom;
        req_rd     = 5'($urandom);
        got_lat = 1;
        while (!resp_valid && got_lat < 10) begin
            @(posedge clk); #1; got_lat++;
        end
        if (!resp_valid) check("resp_valid_timeout", 64'(resp_valid), 64'd1);
        got_pack = {resp_err, resp_cause, resp_we, resp_rd, resp_data};
    endtask

    task automatic finish_resp(input int stall);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_hold",
                  64'({resp_valid, req_ready, dm_rd_en, dm_wr_en, resp_err, resp_cause, resp_we, resp_rd, resp_data}),
                  64'({1'b1, 1'b0, 1'b0, 1'b0, got_pack}));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("release_req_ready", 64'(req_ready), 64'd1);
        check("release_resp_valid", 64'(resp_valid), 64'd0);
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                           input logic [11:0] off, input logic [31:0] wd, input logic [4:0] rd,
                           input int stall, input string tag);
        logic [40:0] exp;
        logic [31:0] exp_ea;
        logic        ok;
        logic [2:0]  emode;
        exp_q.push_back(model_req(st, f3, base, off, wd, rd));
        exp_ea = m_ea;
        issue(st, f3, base, off, wd, rd);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            exp = exp_q.pop_front();
            ok  = (exp[39:38] == 2'd0);
            check({tag, "_resp"}, 64'(got_pack), 64'(exp));
            check({tag, "_lat"}, 64'(got_lat), ok ? 64'd2 : 64'd1);
            check({tag, "_rd_en_cycles"}, 64'(en_rd_total - rd0), (ok && !st) ? 64'd1 : 64'd0);
            check({tag, "_wr_en_cycles"}, 64'(en_wr_total - wr0), (ok && st) ? 64'd1 : 64'd0);
            if (ok) begin
                emode = (f3 == 3'd4) ? 3'd3 : (f3 == 3'd5) ? 3'd4 : f3;
                check({tag, "_dm_addr"}, 64'(en_addr), 64'(exp_ea));
                check({tag, "_dm_mode"}, 64'(en_mode), 64'(emode));
                if (st) check({tag, "_dm_wdata"}, 64'(en_wdata), 64'(wd));
            end
        end
        finish_resp(stall);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"},  64'(req_ready),  64'd1);
        check({tag, "_dm_rd_en"},   64'(dm_rd_en),   64'd0);
        check({tag, "_dm_wr_en"},   64'(dm_wr_en),   64'd0);
        check({tag, "_dm_addr"},    64'(dm_addr),    64'd0);
        check({tag, "_dm_mode"},    64'(dm_mode),    64'd0);
        check({tag, "_dm_wdata"},   64'(dm_wdata),   64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_data"},  64'(resp_data),  64'd0);
        check({tag, "_resp_rd"},    64'(resp_rd),    64'd0);
        check({tag, "_resp_we"},    64'(resp_we),    64'd0);
        check({tag, "_resp_err"},   64'(resp_err),   64'd0);
        check({tag, "_resp_cause"}, 64'(resp_cause), 64'd0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [11:0] off;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [1:0]  cause;
        logic [31:0] data;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  mode;
    } vec_t;

    vec_t tbl [$];

    task automatic add_vec(input logic st, input logic [2:0] f3, input logic [31:0] base,
                           input logic [11:0] off, input logic [31:0] wd, input logic [4:0] rd,
                           input logic [1:0] cause, input logic [31:0] data, input logic we,
                           input logic [31:0] addr, input logic [2:0] mode);
        vec_t v;
        v.st = st; v.f3 = f3; v.base = base; v.off = off; v.wd = wd; v.rd = rd;
        v.cause = cause; v.data = data; v.we = we; v.addr = addr; v.mode = mode;
        tbl.push_back(v);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int a1;
        int a2;
        int diff;
        logic        r_st;
        logic [2:0]  r_f3;
        logic [31:0] r_base;
        logic [11:0] r_off;
        int          sel;

        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i * 7 + 3);
        rst = 1'b1; mem_load = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_base = 32'd0;
        req_offset = 12'd0; req_wdata = 32'd0; req_rd = 5'd0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mem_load = 1'b0;
        rst = 1'b0;
        check_reset_vals("reset");

        //       st    f3    base          off      wdata          rd   cause data          we    addr    mode
        add_vec(1'b1, 3'd2, 32'd8,        12'h004, 32'hDEADBEEF, 5'd5, 2'd0, 32'h0,        1'b0, 32'd12, 3'd2);
        add_vec(1'b0, 3'd2, 32'd12,       12'h000, 32'h0,        5'd5, 2'd0, 32'hDEADBEEF, 1'b1, 32'd12, 3'd2);
        add_vec(1'b1, 3'd0, 32'd20,       12'h000, 32'h12345680, 5'd0, 2'd0, 32'h0,        1'b0, 32'd20, 3'd0);
        add_vec(1'b0, 3'd0, 32'd20,       12'h000, 32'h0,        5'd7, 2'd0, 32'hFFFFFF80, 1'b1, 32'd20, 3'd0);
        add_vec(1'b0, 3'd4, 32'd20,       12'h000, 32'h0,        5'd7, 2'd0, 32'h00000080, 1'b1, 32'd20, 3'd3);
        add_vec(1'b0, 3'd1, 32'h21,       12'h000, 32'h0,        5'd9, 2'd1, 32'h0,        1'b0, 32'd0,  3'd0);
        add_vec(1'b0, 3'd2, 32'd0,        12'hFFC, 32'h0,        5'd9, 2'd2, 32'h0,        1'b0, 32'd0,  3'd0);
        add_vec(1'b0, 3'd2, 32'd96,       12'h000, 32'h0,        5'd3, 2'd0, 32'hB8B1AAA3, 1'b1, 32'd96, 3'd2);
        add_vec(1'b0, 3'd2, 32'd97,       12'h000, 32'h0,        5'd3, 2'd1, 32'h0,        1'b0, 32'd0,  3'd0);
        add_vec(1'b0, 3'd0, 32'd100,      12'h000, 32'h0,        5'd3, 2'd2, 32'h0,        1'b0, 32'd0,  3'd0);
        add_vec(1'b0, 3'd6, 32'd0,        12'h000, 32'h0,        5'd3, 2'd3, 32'h0,        1'b0, 32'd0,  3'd0);
        add_vec(1'b0, 3'd1, 32'd98,       12'h000, 32'h0,        5'd4, 2'd0, 32'hFFFFB8B1, 1'b1, 32'd98, 3'd1);
        add_vec(1'b0, 3'd5, 32'd98,       12'h000, 32'h0,        5'd4, 2'd0, 32'h0000B8B1, 1'b1, 32'd98, 3'd4);
        add_vec(1'b1, 3'd4, 32'd0,        12'h000, 32'h55,       5'd1, 2'd3, 32'h0,        1'b0, 32'd0,  3'd0);
        add_vec(1'b0, 3'd2, 32'd99,       12'h000, 32'h0,        5'd1, 2'd1, 32'h0,        1'b0, 32'd0,  3'd0);
        add_vec(1'b0, 3'd7, 32'd1,        12'h000, 32'h0,        5'd1, 2'd3, 32'h0,        1'b0, 32'd0,  3'd0);
        add_vec(1'b0, 3'd2, 32'd12,       12'h000, 32'h0,        5'd0, 2'd0, 32'hDEADBEEF, 1'b0, 32'd12, 3'd2);
        add_vec(1'b0, 3'd2, 32'h10,       12'h800, 32'h0,        5'd2, 2'd2, 32'h0,        1'b0, 32'd0,  3'd0);
        add_vec(1'b1, 3'd1, 32'd50,       12'hFFF, 32'hABCD,     5'd2, 2'd1, 32'h0,        1'b0, 32'd0,  3'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            run_req(tbl[i].st, tbl[i].f3, tbl[i].base, tbl[i].off, tbl[i].wd, tbl[i].rd,
                    (i == 1) ? 5 : 0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_err", i),   64'(got_pack[40]),    64'(tbl[i].cause != 2'd0));
            check($sformatf("tbl%0d_cause", i), 64'(got_pack[39:38]), 64'(tbl[i].cause));
            check($sformatf("tbl%0d_we", i),    64'(got_pack[37]),    64'(tbl[i].we));
            check($sformatf("tbl%0d_data", i),  64'(got_pack[31:0]),  64'(tbl[i].data));
            check($sformatf("tbl%0d_lat", i),   64'(got_lat),         (tbl[i].cause == 2'd0) ? 64'd2 : 64'd1);
            if (tbl[i].cause == 2'd0) begin
                check($sformatf("tbl%0d_addr", i), 64'(en_addr), 64'(tbl[i].addr));
                check($sformatf("tbl%0d_mode", i), 64'(en_mode), 64'(tbl[i].mode));
            end
        end

        // Back-to-back: one accept every 3 cycles with resp_ready released at once.
        run_req(1'b0, 3'd2, 32'd12, 12'h000, 32'h0, 5'd6, 0, "b2b_a");
        a1 = acc_cyc;
        run_req(1'b0, 3'd2, 32'd12, 12'h000, 32'h0, 5'd6, 0, "b2b_b");
        a2 = acc_cyc;
        check("b2b_period", 64'(a2 - a1), 64'd3);

        // Reset during RESP drops resp_valid on the next edge.
        issue(1'b0, 3'd2, 32'd12, 12'h000, 32'h0, 5'd6);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_ready", 64'(req_ready), 64'd1);
        rst = 1'b0;

        // Reset during the ACCESS cycle of a store: no write, outputs back to reset.
        run_req(1'b1, 3'd2, 32'd40, 12'h000, 32'h11223344, 5'd0, 0, "sw40_prior");
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_base = 32'd40;
        req_offset = 12'h000; req_wdata = 32'hCAFEF00D; req_rd = 5'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_access_wr_before", 64'(dm_wr_en), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_access_wr_gated", 64'(dm_wr_en), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_vals("rst_access");
        run_req(1'b0, 3'd2, 32'd40, 12'h000, 32'h0, 5'd1, 0, "lw40_after");
        check("lw40_prior_value", 64'(got_pack[31:0]), 64'h11223344);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            r_st = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            sel  = $urandom_range(0, 9);
            if (sel < 8)       r_base = 32'($urandom_range(0, 104));
            else if (sel == 8) r_base = $urandom;
            else               r_base = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r_off = 12'($urandom);
            else                           r_off = 12'($urandom_range(0, 8)) - 12'd4;
            run_req(r_st, r_f3, r_base, r_off, $urandom, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end

        diff = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (dm_mem[i] !== ref_mem[i]) diff++;
        check("mem_image_diff_bytes", 64'(diff), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
